// File: rtl/sipo16_rx.sv
// sipo16_rx: serial-in / parallel-out word receiver.
// Bits arrive one per ser_valid cycle and are assembled into a WIDTH-bit word.
// The bit order is chosen per word from msb_first on the word's first bit.
// Each completed word moves into a holding register (Q_par) that a consumer
// takes over a valid/ready handshake, so the next word can be received while
// the previous one waits.
// Error flags are sticky:
//   overrun   - a completed word was dropped because the holding register was full.
//   frame_err - a partial word was abandoned after TIMEOUT idle cycles.
// Both flags clear only on clear or _rst.

module sipo16_rx #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     _rst,
    input  logic                     ser_in,
    input  logic                     ser_valid,
    input  logic                     msb_first,
    input  logic                     clear,
    output logic [WIDTH-1:0]         Q_par,
    output logic                     par_valid,
    input  logic                     par_ready,
    output logic                     busy,
    output logic [$clog2(WIDTH):0]   bit_cnt,
    output logic                     overrun,
    output logic                     frame_err
);

    // Widths of the bit counter and the inter-bit idle counter.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    // The counter value reached on the last bit of a word.
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);

    // The idle count from which one more empty cycle hits TIMEOUT.
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e            state_q,     state_d;
    logic [WIDTH-1:0]  sr_q,        sr_d;
    logic [CW-1:0]     bit_cnt_q,   bit_cnt_d;
    logic              dir_q,       dir_d;
    logic [IW-1:0]     idle_q,      idle_d;
    logic [WIDTH-1:0]  q_par_q,     q_par_d;
    logic              par_valid_q, par_valid_d;
    logic              overrun_q,   overrun_d;
    logic              frame_err_q, frame_err_d;

    logic [WIDTH-1:0]  shifted;
    logic              transfer;

    // Shift one bit into the register in the requested direction.
    // dir = 1: the bit enters at the LSB end (MSB-first order).
    // dir = 0: the bit enters at the MSB end (LSB-first order).
    function automatic logic [WIDTH-1:0] shift_in(
        input logic [WIDTH-1:0] sr,
        input logic             bit_in,
        input logic             dir
    );
        if (dir) begin
            return {sr[WIDTH-2:0], bit_in};
        end
        return {bit_in, sr[WIDTH-1:1]};
    endfunction

    // Next-state logic for the receive FSM, holding register and error flags.
    always_comb begin
        // NOTE: every _d starts from its _q, so a path that does not assign it still has a value and no latch is inferred.
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        dir_d       = dir_q;
        idle_d      = idle_q;
        q_par_d     = q_par_q;
        par_valid_d = par_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        // On a word's first bit the direction comes straight from msb_first.
        // After that it comes from the value latched in dir_q.
        shifted  = shift_in(sr_q, ser_in, (state_q == IDLE) ? msb_first : dir_q);
        transfer = par_valid_q & par_ready;

        if (transfer) begin
            par_valid_d = 1'b0;
        end

        if (clear) begin
            // Soft clear overrides everything, including a same-cycle bit.
            state_d     = IDLE;
            sr_d        = '0;
            bit_cnt_d   = '0;
            idle_d      = '0;
            q_par_d     = '0;
            par_valid_d = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    idle_d = '0;
                    if (ser_valid) begin
                        // WIDTH >= 2, so the first bit never completes a word.
                        dir_d     = msb_first;
                        sr_d      = shifted;
                        bit_cnt_d = CW'(1);
                        state_d   = SHIFT;
                    end
                end

                SHIFT: begin
                    if (ser_valid) begin
                        sr_d   = shifted;
                        idle_d = '0;
                        if (bit_cnt_q == CNT_LAST) begin
                            // This edge accepts the last bit of the word.
                            bit_cnt_d = '0;
                            state_d   = IDLE;
                            // Keep the word if the holding register is empty,
                            // or if it is being emptied on this same edge.
                            if (!par_valid_q || transfer) begin
                                q_par_d     = shifted;
                                par_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end else if (TIMEOUT > 0) begin
                        if (idle_q == IDLE_LAST) begin
                            // The idle count reaches TIMEOUT on this edge.
                            // Abandon the partial word and flag a framing error.
                            sr_d        = '0;
                            bit_cnt_d   = '0;
                            idle_d      = '0;
                            state_d     = IDLE;
                            frame_err_d = 1'b1;
                        end else begin
                            idle_d = idle_q + IW'(1);
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State registers: asynchronous reset discards any partial word.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            dir_q       <= 1'b0;
            idle_q      <= '0;
            q_par_q     <= '0;
            par_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register update from the same pre-edge values.
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            dir_q       <= dir_d;
            idle_q      <= idle_d;
            q_par_q     <= q_par_d;
            par_valid_q <= par_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Every output comes directly from a register.
    assign Q_par     = q_par_q;
    assign par_valid = par_valid_q;
    assign busy      = (state_q == SHIFT);
    assign bit_cnt   = bit_cnt_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo16_rx.sv
// Directed testbench for sipo16_rx (WIDTH = 16, TIMEOUT = 64).
// Inputs change 1 ns after a rising edge.
// Outputs are sampled at that same point, so they show the result of the previous edge.

module tb_sipo16_rx;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ser_in;
    logic        ser_valid;
    logic        msb_first;
    logic        clear;
    logic        par_ready;
    logic [15:0] q_par;
    logic        par_valid;
    logic        busy;
    logic [4:0]  bit_cnt;
    logic        overrun;
    logic        frame_err;

    int          n_checks = 0;
    int          n_errors = 0;

    // Words taken by the consumer, in order.
    logic [15:0] got[$];

    // Count of cycles where par_valid was low while tracking is enabled.
    bit          track_pv = 1'b0;
    int          pv_drops = 0;

    always #5 clk = ~clk;

    sipo16_rx #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        ._rst      (rst_n),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .msb_first (msb_first),
        .clear     (clear),
        .Q_par     (q_par),
        .par_valid (par_valid),
        .par_ready (par_ready),
        .busy      (busy),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    // Advance one clock.
    // Before the edge, record a handshake transfer if one is about to happen.
    task automatic tick();
        if (par_valid && par_ready) got.push_back(q_par);
        @(posedge clk);
        #1;
        if (track_pv && !par_valid) pv_drops++;
    endtask

    task automatic send_bit(input logic b);
        ser_in    = b;
        ser_valid = 1'b1;
        tick();
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    // Send a 16-bit word.
    //   gap           - idle cycles inserted between bits.
    //   toggle        - flip msb_first after the first bit.
    //   ready_on_last - raise par_ready only on the edge that takes the last bit.
    task automatic send_word(input logic [15:0] w, input logic msb, input int gap,
                             input bit toggle, input bit ready_on_last);
        for (int i = 0; i < 16; i++) begin
            msb_first = (toggle && i > 0) ? ~msb_first : msb;
            if (ready_on_last && i == 15) par_ready = 1'b1;
            send_bit(msb ? w[15-i] : w[i]);
            if (ready_on_last && i == 15) par_ready = 1'b0;
            if (i < 15) repeat (gap) tick();
        end
    endtask

    task automatic consume();
        par_ready = 1'b1;
        tick();
        par_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        ser_in    = 1'b0;
        ser_valid = 1'b0;
        msb_first = 1'b0;
        clear     = 1'b0;
        par_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({q_par, par_valid, busy, bit_cnt, overrun, frame_err} !== 25'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got q=%h pv=%b busy=%b cnt=%0d ovr=%b ferr=%b required all 0",
                     q_par, par_valid, busy, bit_cnt, overrun, frame_err);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_msb_first();
        logic [15:0] w = 16'hA5C3;
        int bad = 0;
        msb_first = 1'b1;
        par_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL msb_idle_busy: got %b required 0", busy);
        end
        for (int i = 0; i < 16; i++) begin
            send_bit(w[15-i]);
            if (i < 15 && (busy !== 1'b1 || bit_cnt !== 5'(i + 1))) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL msb_busy_cnt: %0d bad samples required 0", bad);
        end
        n_checks++;
        if (q_par !== 16'hA5C3 || par_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL msb_word: got q=%h pv=%b required q=a5c3 pv=1", q_par, par_valid);
        end
        n_checks++;
        if (busy !== 1'b0 || bit_cnt !== 5'd0 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL msb_done_state: got busy=%b cnt=%0d ovr=%b required 0 0 0", busy, bit_cnt, overrun);
        end
        tick();
        n_checks++;
        if (q_par !== 16'hA5C3 || par_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL msb_hold: got q=%h pv=%b required q=a5c3 pv=1", q_par, par_valid);
        end
        got.delete();
        consume();
        n_checks++;
        if (par_valid !== 1'b0 || got.size() != 1) begin
            n_errors++;
            $display("FAIL msb_consume: got pv=%b transfers=%0d required pv=0 transfers=1", par_valid, got.size());
        end else begin
            n_checks++;
            if (got[0] !== 16'hA5C3) begin
                n_errors++;
                $display("FAIL msb_transfer_word: got %h required a5c3", got[0]);
            end
        end
    endtask

    task automatic test_lsb_gaps();
        send_word(16'h1234, 1'b0, 1, 1'b1, 1'b0);
        n_checks++;
        if (q_par !== 16'h1234 || par_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL lsb_word: got q=%h pv=%b required q=1234 pv=1", q_par, par_valid);
        end
        consume();
    endtask

    task automatic test_overrun();
        msb_first = 1'b1;
        send_word(16'h00FF, 1'b1, 0, 1'b0, 1'b0);
        send_word(16'hFF00, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (q_par !== 16'h00FF || par_valid !== 1'b1 || overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL overrun_drop: got q=%h pv=%b ovr=%b required q=00ff pv=1 ovr=1", q_par, par_valid, overrun);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if ({q_par, par_valid, overrun, frame_err, bit_cnt} !== 24'd0) begin
            n_errors++;
            $display("FAIL overrun_clear: got q=%h pv=%b ovr=%b ferr=%b cnt=%0d required all 0",
                     q_par, par_valid, overrun, frame_err, bit_cnt);
        end
        got.delete();
        send_word(16'h00FF, 1'b1, 0, 1'b0, 1'b0);
        send_word(16'hFF00, 1'b1, 0, 1'b0, 1'b1);
        n_checks++;
        if (q_par !== 16'hFF00 || par_valid !== 1'b1 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL overrun_same_edge: got q=%h pv=%b ovr=%b required q=ff00 pv=1 ovr=0", q_par, par_valid, overrun);
        end
        n_checks++;
        if (got.size() != 1 || got[0] !== 16'h00FF) begin
            n_errors++;
            $display("FAIL overrun_transfer: got %0d transfers first=%h required 1 transfer of 00ff",
                     got.size(), (got.size() > 0) ? got[0] : 16'hxxxx);
        end
        // The FF00 word stays pending for the timeout test.
    endtask

    task automatic test_timeout();
        repeat (5) send_bit(1'b1);
        repeat (TIMEOUT - 1) tick();
        n_checks++;
        if (bit_cnt !== 5'd5 || busy !== 1'b1 || frame_err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_before: got cnt=%0d busy=%b ferr=%b required 5 1 0", bit_cnt, busy, frame_err);
        end
        tick();
        n_checks++;
        if (bit_cnt !== 5'd0 || busy !== 1'b0 || frame_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_abort: got cnt=%0d busy=%b ferr=%b required 0 0 1", bit_cnt, busy, frame_err);
        end
        n_checks++;
        if (par_valid !== 1'b1 || q_par !== 16'hFF00) begin
            n_errors++;
            $display("FAIL timeout_holding: got q=%h pv=%b required q=ff00 pv=1", q_par, par_valid);
        end
        consume();
        // A bit arriving on the cycle the count would reach TIMEOUT is accepted.
        repeat (3) send_bit(1'b0);
        repeat (TIMEOUT - 1) tick();
        send_bit(1'b1);
        n_checks++;
        if (bit_cnt !== 5'd4 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_priority: got cnt=%0d busy=%b required 4 1", bit_cnt, busy);
        end
        repeat (TIMEOUT) tick();
        n_checks++;
        if (bit_cnt !== 5'd0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_abort2: got cnt=%0d busy=%b required 0 0", bit_cnt, busy);
        end
        send_word(16'hBEEF, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (q_par !== 16'hBEEF || par_valid !== 1'b1 || frame_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_next_word: got q=%h pv=%b ferr=%b required q=beef pv=1 ferr=1", q_par, par_valid, frame_err);
        end
        // BEEF stays pending and frame_err stays set for the reset test.
    endtask

    task automatic test_reset_clear_mid();
        msb_first = 1'b1;
        repeat (7) send_bit(1'b1);
        n_checks++;
        if (bit_cnt !== 5'd7) begin
            n_errors++;
            $display("FAIL midreset_pre: got cnt=%0d required 7", bit_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({q_par, par_valid, busy, bit_cnt, overrun, frame_err} !== 25'd0) begin
            n_errors++;
            $display("FAIL midreset_async: got q=%h pv=%b busy=%b cnt=%0d ovr=%b ferr=%b required all 0",
                     q_par, par_valid, busy, bit_cnt, overrun, frame_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_word(16'h3C3C, 1'b1, 0, 1'b0, 1'b0);
        send_word(16'hC3C3, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (overrun !== 1'b1 || q_par !== 16'h3C3C) begin
            n_errors++;
            $display("FAIL midclear_pre: got ovr=%b q=%h required ovr=1 q=3c3c", overrun, q_par);
        end
        repeat (9) send_bit(1'b1);
        clear     = 1'b1;
        ser_in    = 1'b1;
        ser_valid = 1'b1;
        tick();
        clear     = 1'b0;
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        n_checks++;
        if ({q_par, par_valid, busy, bit_cnt, overrun, frame_err} !== 25'd0) begin
            n_errors++;
            $display("FAIL midclear_state: got q=%h pv=%b busy=%b cnt=%0d ovr=%b ferr=%b required all 0",
                     q_par, par_valid, busy, bit_cnt, overrun, frame_err);
        end
        send_word(16'hC001, 1'b1, 0, 1'b0, 1'b0);
        n_checks++;
        if (q_par !== 16'hC001 || par_valid !== 1'b1 || bit_cnt !== 5'd0) begin
            n_errors++;
            $display("FAIL midclear_next_word: got q=%h pv=%b cnt=%0d required q=c001 pv=1 cnt=0", q_par, par_valid, bit_cnt);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        // Consumer always ready: three transfers in order.
        got.delete();
        par_ready = 1'b1;
        send_word(16'h0001, 1'b1, 0, 1'b0, 1'b0);
        send_word(16'h8000, 1'b1, 0, 1'b0, 1'b0);
        send_word(16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
        tick();
        par_ready = 1'b0;
        n_checks++;
        if (got.size() != 3) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d transfers required 3", got.size());
        end else begin
            n_checks++;
            if (got[0] !== 16'h0001 || got[1] !== 16'h8000 || got[2] !== 16'hFFFF) begin
                n_errors++;
                $display("FAIL b2b_order: got %h %h %h required 0001 8000 ffff", got[0], got[1], got[2]);
            end
        end
        n_checks++;
        if (overrun !== 1'b0 || frame_err !== 1'b0 || par_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_flags: got ovr=%b ferr=%b pv=%b required 0 0 0", overrun, frame_err, par_valid);
        end
        // Ready only on completion edges: par_valid never drops once the first word lands.
        got.delete();
        send_word(16'h0001, 1'b1, 0, 1'b0, 1'b0);
        track_pv = 1'b1;
        send_word(16'h8000, 1'b1, 0, 1'b0, 1'b1);
        send_word(16'hFFFF, 1'b1, 0, 1'b0, 1'b1);
        track_pv = 1'b0;
        n_checks++;
        if (pv_drops != 0 || q_par !== 16'hFFFF || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_continuous: got drops=%0d q=%h ovr=%b required 0 ffff 0", pv_drops, q_par, overrun);
        end
        n_checks++;
        if (got.size() != 2 || got[0] !== 16'h0001 || got[1] !== 16'h8000) begin
            n_errors++;
            $display("FAIL b2b_cont_order: got %0d transfers required 0001 then 8000", got.size());
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_gaps();
        test_overrun();
        test_timeout();
        test_reset_clear_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
